// File: rtl/aes_round_pipe.sv
// AES-128 encryption round stage with valid/ready flow control.
// Per beat: SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey; the tag rides along.
// SPLIT=0 registers the whole round once; SPLIT=1 adds a register after SubBytes.
module aes_round_pipe #(
  parameter int SPLIT    = 0,
  parameter int TAG_W    = 8,
  parameter int RST_DATA = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_do_mix,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic [TAG_W-1:0] out_tag
);

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse as x^254 (square-and-multiply); maps 0 to 0 as SubBytes requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // S-box: field inverse followed by the affine transform (rotations + 0x63)
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // Everything after SubBytes; the final cipher round skips MixColumns
  function automatic logic [127:0] round_tail(input logic [127:0] sub, input logic [127:0] key,
                                              input logic mix);
    logic [127:0] sr;
    sr = shift_rows(sub);
    return (mix ? mix_columns(sr) : sr) ^ key;
  endfunction

  // Source of the output stage: either the input port or the SubBytes register
  logic [127:0]       fin_sub;
  logic [127:0]       fin_key;
  logic               fin_mix;
  logic               fin_vld;
  logic [TAG_W-1:0]   fin_tag;

  logic               vld_p1;
  logic               ld_p1;
  logic [127+TAG_W:0] pay_p1;
  logic [127+TAG_W:0] nxt_p1;

  assign ld_p1     = ~vld_p1 | out_ready;
  assign nxt_p1    = {round_tail(fin_sub, fin_key, fin_mix), fin_tag};
  assign out_valid = vld_p1;
  assign out_state = pay_p1[127+TAG_W:TAG_W];
  assign out_tag   = pay_p1[TAG_W-1:0];

  // ---- output stage (p1) ----
  // Output valid: refill whenever the stage is empty or being drained this edge
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)      vld_p1 <= 1'b0;
    else if (ld_p1) vld_p1 <= fin_vld;

  if (RST_DATA != 0) begin : g_p1_rst
    // Output payload, cleared by reset; bubbles leave it untouched
    always_ff @(posedge clk or negedge rstn)
      if (!rstn)                 pay_p1 <= '0;
      else if (ld_p1 && fin_vld) pay_p1 <= nxt_p1;
  end else begin : g_p1_hold
    // Output payload without reset; bubbles leave it untouched
    always_ff @(posedge clk)
      if (ld_p1 && fin_vld) pay_p1 <= nxt_p1;
  end

  if (SPLIT != 0) begin : g_split
    logic               vld_p0;
    logic               ld_p0;
    logic [256+TAG_W:0] pay_p0;
    logic [256+TAG_W:0] nxt_p0;

    assign ld_p0    = ~vld_p0 | ld_p1;
    assign nxt_p0   = {sub_bytes(in_state), in_key, in_do_mix, in_tag};
    assign in_ready = ld_p0;
    assign fin_vld  = vld_p0;
    assign fin_sub  = pay_p0[256+TAG_W -: 128];
    assign fin_key  = pay_p0[128+TAG_W -: 128];
    assign fin_mix  = pay_p0[TAG_W];
    assign fin_tag  = pay_p0[TAG_W-1:0];

    // ---- SubBytes stage (p0) ----
    // Front valid: advances when it is empty or the output stage takes its beat
    always_ff @(posedge clk or negedge rstn)
      if (!rstn)      vld_p0 <= 1'b0;
      else if (ld_p0) vld_p0 <= in_valid;

    if (RST_DATA != 0) begin : g_p0_rst
      // Front payload (SubBytes result, key, mix flag, tag), cleared by reset
      always_ff @(posedge clk or negedge rstn)
        if (!rstn)                  pay_p0 <= '0;
        else if (ld_p0 && in_valid) pay_p0 <= nxt_p0;
    end else begin : g_p0_hold
      // Front payload without reset
      always_ff @(posedge clk)
        if (ld_p0 && in_valid) pay_p0 <= nxt_p0;
    end
  end else begin : g_flat
    assign in_ready = ld_p1;
    assign fin_vld  = in_valid;
    assign fin_sub  = sub_bytes(in_state);
    assign fin_key  = in_key;
    assign fin_mix  = in_do_mix;
    assign fin_tag  = in_tag;
  end

endmodule
